reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, register word width.
REQ-002 SHALL have parameter NB_REG, default 5, register address width.
REQ-003 SHALL have parameter NB_BYTE, default 8, transmitted byte width.
REQ-004 SHALL have parameter N_REGS, default 32, number of registers dumped.
REQ-005 SHALL have port clock_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start_i, input, 1 bit: request to dump the register bank.
REQ-008 SHALL have port cntl_read_debug_reg_o, output, 1 bit: 1 steers the bank read port A address to addr_debug_unit_o.
REQ-009 SHALL have port addr_debug_unit_o, output, NB_REG bits: register index being read.
REQ-010 SHALL have port data_reg_debug_unit_i, input, NB_DATA bits: combinational read data for addr_debug_unit_o.
REQ-011 SHALL have port tx_data_o, output, NB_BYTE bits: byte to the transmitter.
REQ-012 SHALL have port tx_start_o, output, 1 bit: one-cycle transmit request.
REQ-013 SHALL have port tx_done_i, input, 1 bit: transmitter finished the current byte.
REQ-014 SHALL have port busy_o, output, 1 bit: dump in progress.
REQ-015 SHALL have port done_o, output, 1 bit: one-cycle pulse at dump completion.

Function
REQ-016 FSM states SHALL be: IDLE, SELECT, SEND, WAIT_TX, DONE (and CHK when enabled).
REQ-017 In IDLE, start_i=1 SHALL move the FSM to SELECT with the register counter at 0 and the byte counter at 0.
REQ-018 In SELECT, the block SHALL drive addr_debug_unit_o = register counter, latch data_reg_debug_unit_i into a shift register at the clock edge, and go to SEND; SELECT lasts 1 cycle.
REQ-019 In SEND, tx_start_o SHALL be 1 for exactly 1 cycle with tx_data_o = shift[7:0], then the FSM SHALL go to WAIT_TX.
REQ-020 In WAIT_TX, tx_done_i=1 SHALL advance as follows: byte counter < 3 -> shift right by NB_BYTE, byte counter +1, go to SEND; byte counter = 3 and register counter < N_REGS-1 -> register counter +1, byte counter 0, go to SELECT; otherwise go to DONE.
REQ-021 Bytes SHALL be sent least-significant first, with registers in ascending order: 4*N_REGS bytes in total.
REQ-022 tx_done_i SHALL be ignored in every state other than WAIT_TX, including the SEND cycle.
REQ-023 start_i SHALL be ignored while busy_o=1.
REQ-024 In DONE, done_o SHALL be 1 for 1 cycle, then the FSM SHALL return to IDLE.
REQ-025 busy_o and cntl_read_debug_reg_o SHALL be 1 in every state except IDLE.
REQ-026 addr_debug_unit_o SHALL be 0 in IDLE.
REQ-027 tx_data_o SHALL be registered and hold its last value outside SEND.
REQ-028 Counters SHALL never wrap: the register counter stops at N_REGS-1 and the byte counter stops at 3.

Reset
REQ-029 reset_i=1 SHALL force, at the next edge and from any state including mid-byte, the FSM to IDLE and all outputs, counters, and the shift register to 0.
REQ-030 After reset, a new start_i SHALL restart the dump at register 0 and byte 0; no partial-dump state survives.

Configuration
REQ-031 With DUMP_CHECKSUM_EN defined, after the last byte the FSM SHALL enter CHK and send one extra byte equal to the XOR of all 4*N_REGS bytes sent (same SEND/WAIT_TX handshake), then go to DONE.
REQ-032 With DUMP_CHECKSUM_EN undefined, no checksum register or CHK state SHALL exist, and WAIT_TX SHALL go directly to DONE.

Structure
REQ-033 State encodings, NB_BYTE, and N_REGS SHALL be defined in the shared parameters.vh header.
REQ-034 Byte shifting and the byte counter SHALL be in one sub-module, word_serializer (load, shift, byte_last); the FSM and register counter SHALL stay in reg_dump_unit.

Verification
REQ-035 With bank reg k = 0xA0B0C000+k and tx_done_i returned 3 cycles after each tx_start_o, the bench SHALL check 128 bytes; register 5 yields 05 C0 B0 A0; done_o pulses once.
REQ-036 With tx_done_i delayed 20 cycles, the bench SHALL check: one tx_start_o per byte, tx_data_o stable, no state advance before tx_done_i.
REQ-037 With start_i pulsed during byte 40 and tx_done_i asserted in the SEND cycle, the bench SHALL check: both ignored, still 128 bytes in order.
REQ-038 With reset_i asserted at byte 50, the bench SHALL check: next cycle busy_o=0 and tx_start_o=0; a restarted dump begins with register 0 byte 0.
REQ-039 With DUMP_CHECKSUM_EN defined, all regs 0 except r1=0x000000FF, the bench SHALL check 129 bytes with last byte 0xFF; without the macro, 128 bytes.

Source files
------------

// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register dump unit: default sizes and FSM state encoding.
// The CHK state only exists when DUMP_CHECKSUM_EN is defined.
package reg_dump_unit_pkg;

  localparam int unsigned DefNbByte = 8;
  localparam int unsigned DefNRegs  = 32;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StSend   = 3'd2,
    StWaitTx = 3'd3,
    StDone   = 3'd4
`ifdef DUMP_CHECKSUM_EN
    ,
    StChk    = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/reg_dump_unit_word_serializer.sv
// Splits one register word into bytes, least-significant first, and tracks the byte index.
module reg_dump_unit_word_serializer #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               shift,
  input  logic [NB_DATA-1:0] word,
  output logic [NB_BYTE-1:0] next_byte,
  output logic               byte_last
);

  localparam int unsigned BytesPerWord = NB_DATA / NB_BYTE;
  localparam int unsigned CntW = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BytesPerWord - 1);

  logic [NB_DATA-1:0] shift_q;
  logic [CntW-1:0]    cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
    end else if (shift && !byte_last) begin
      shift_q <= shift_q >> NB_BYTE;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign byte_last = (cnt_q == LastCnt);

  // Byte that will sit at the bottom of the shift register after this edge.
  always_comb begin
    next_byte = shift_q[NB_BYTE-1:0];
    if (load) begin
      next_byte = word[NB_BYTE-1:0];
    end else if (shift) begin
      next_byte = shift_q[2*NB_BYTE-1:NB_BYTE];
    end
  end

endmodule

// File: rtl/reg_dump_unit.sv
// Dumps a register bank byte by byte to a transmitter with a start/done handshake.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_BYTE = DefNbByte,
  parameter int unsigned N_REGS  = DefNRegs
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               cntl_read_debug_reg_o,
  output logic [NB_REG-1:0]  addr_debug_unit_o,
  input  logic [NB_DATA-1:0] data_reg_debug_unit_i,
  output logic [NB_BYTE-1:0] tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [NB_REG-1:0] LastReg = NB_REG'(N_REGS - 1);

  state_e              state_q;
  logic [NB_REG-1:0]   reg_cnt_q;
  logic                ser_clear;
  logic                ser_load;
  logic                ser_shift;
  logic [NB_BYTE-1:0]  next_byte;
  logic                byte_last;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]  chk_q;
  logic                chk_phase_q;
`endif

  assign ser_clear = (state_q == StIdle) && start_i;
  assign ser_load  = (state_q == StSelect);
  // tx_done_i only matters while waiting on the transmitter.
  assign ser_shift = (state_q == StWaitTx) && tx_done_i && !byte_last;

  assign addr_debug_unit_o = reg_cnt_q;

  reg_dump_unit_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clock     (clock_i),
    .reset     (reset_i),
    .clear     (ser_clear),
    .load      (ser_load),
    .shift     (ser_shift),
    .word      (data_reg_debug_unit_i),
    .next_byte (next_byte),
    .byte_last (byte_last)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q               <= StIdle;
      reg_cnt_q             <= '0;
      tx_data_o             <= '0;
      tx_start_o            <= 1'b0;
      busy_o                <= 1'b0;
      cntl_read_debug_reg_o <= 1'b0;
      done_o                <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      chk_q                 <= '0;
      chk_phase_q           <= 1'b0;
`endif
    end else begin
      tx_start_o <= 1'b0;
      done_o     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q               <= StSelect;
            reg_cnt_q             <= '0;
            busy_o                <= 1'b1;
            cntl_read_debug_reg_o <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            chk_q                 <= '0;
            chk_phase_q           <= 1'b0;
`endif
          end
        end
        StSelect: begin
          state_q    <= StSend;
          tx_start_o <= 1'b1;
          tx_data_o  <= next_byte;
`ifdef DUMP_CHECKSUM_EN
          chk_q      <= chk_q ^ next_byte;
`endif
        end
        StSend: begin
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (tx_done_i) begin
            if (!byte_last) begin
              state_q    <= StSend;
              tx_start_o <= 1'b1;
              tx_data_o  <= next_byte;
`ifdef DUMP_CHECKSUM_EN
              chk_q      <= chk_q ^ next_byte;
`endif
            end else if (reg_cnt_q < LastReg) begin
              state_q   <= StSelect;
              reg_cnt_q <= reg_cnt_q + 1'b1;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              if (chk_phase_q) begin
                state_q <= StDone;
                done_o  <= 1'b1;
              end else begin
                state_q <= StChk;
              end
`else
              state_q <= StDone;
              done_o  <= 1'b1;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        StChk: begin
          state_q     <= StSend;
          chk_phase_q <= 1'b1;
          tx_start_o  <= 1'b1;
          tx_data_o   <= chk_q;
        end
`endif
        StDone: begin
          state_q               <= StIdle;
          reg_cnt_q             <= '0;
          busy_o                <= 1'b0;
          cntl_read_debug_reg_o <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: expected byte stream queued at start, popped per tx_start_o.
module tb_reg_dump_unit;

  logic        clock_i;
  logic        reset_i;
  logic        start_i;
  logic        cntl_read_debug_reg_o;
  logic [4:0]  addr_debug_unit_o;
  logic [31:0] data_reg_debug_unit_i;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_i;
  logic        busy_o;
  logic        done_o;

  logic [31:0] bank [32];
  assign data_reg_debug_unit_i = bank[addr_debug_unit_o];

  reg_dump_unit u_dut (
    .clock_i               (clock_i),
    .reset_i               (reset_i),
    .start_i               (start_i),
    .cntl_read_debug_reg_o (cntl_read_debug_reg_o),
    .addr_debug_unit_o     (addr_debug_unit_o),
    .data_reg_debug_unit_i (data_reg_debug_unit_i),
    .tx_data_o             (tx_data_o),
    .tx_start_o            (tx_start_o),
    .tx_done_i             (tx_done_i),
    .busy_o                (busy_o),
    .done_o                (done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] expq [$];
  logic [7:0] cap  [$];
  int         tx_delay, early_done, start_at, reset_at;
  int         nbytes, n_done, viol, outstanding, wait_cnt;
  logic [7:0] last_byte;
  int         total_bytes;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_checks++;
    if (got !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  // One clock of bench activity, sampled on the falling edge: monitor, transmitter model, pokes.
  task automatic cycle();
    logic [7:0] expected;
    @(negedge clock_i);
    start_i   = 1'b0;
    tx_done_i = 1'b0;
    reset_i   = 1'b0;
    if (!busy_o && addr_debug_unit_o != 5'd0) viol++;
    if (tx_start_o) begin
      if (outstanding != 0) viol++;
      if (!busy_o || !cntl_read_debug_reg_o) viol++;
      if (expq.size() == 0) begin
        check_eq("extra_byte", 32'(nbytes), 32'(total_bytes));
      end else begin
        expected = expq.pop_front();
        check_eq($sformatf("byte%0d", nbytes), 32'(tx_data_o), 32'(expected));
      end
      cap.push_back(tx_data_o);
      nbytes++;
      last_byte   = tx_data_o;
      outstanding = 1;
      wait_cnt    = 0;
      if (early_done != 0) tx_done_i = 1'b1;
      if (nbytes == start_at) start_i = 1'b1;
      if (nbytes == reset_at) reset_i = 1'b1;
    end else begin
      if (busy_o && nbytes > 0 && tx_data_o != last_byte) viol++;
      if (outstanding != 0) begin
        wait_cnt++;
        if (wait_cnt >= tx_delay) begin
          tx_done_i   = 1'b1;
          outstanding = 0;
        end
      end
    end
    if (done_o) n_done++;
  endtask

  task automatic build_expected();
    logic [7:0] x;
    x = 8'h00;
    expq.delete();
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 4; b++) begin
        expq.push_back(bank[r][8*b +: 8]);
        x = x ^ bank[r][8*b +: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    expq.push_back(x);
`endif
    total_bytes = expq.size();
  endtask

  task automatic run_dump(input string tag, input int d, input int early, input int st_at,
                          input int rst_at);
    int cyc;
    int budget;
    tx_delay = d; early_done = early; start_at = st_at; reset_at = rst_at;
    nbytes = 0; n_done = 0; viol = 0; outstanding = 0; wait_cnt = 0;
    cap.delete();
    build_expected();
    budget = 140 * (d + 6) + 200;
    cyc = 0;
    start_i = 1'b1;
    while (n_done == 0 && cyc < budget && !(rst_at > 0 && nbytes >= rst_at)) begin
      cycle();
      cyc++;
    end
    if (rst_at > 0) begin
      cycle();
      check_eq({tag, "_busy_after_reset"}, 32'(busy_o), 32'd0);
      check_eq({tag, "_txstart_after_reset"}, 32'(tx_start_o), 32'd0);
      check_eq({tag, "_done_after_reset"}, 32'(done_o), 32'd0);
      check_eq({tag, "_viol"}, 32'(viol), 32'd0);
      outstanding = 0;
      repeat (3) cycle();
      expq.delete();
      return;
    end
    check_eq({tag, "_no_timeout"}, 32'(cyc < budget), 32'd1);
    repeat (5) cycle();
    check_eq({tag, "_bytes"}, 32'(nbytes), 32'(total_bytes));
    check_eq({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    check_eq({tag, "_viol"}, 32'(viol), 32'd0);
    check_eq({tag, "_queue_left"}, 32'(expq.size()), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_idle_cntl"}, 32'(cntl_read_debug_reg_o), 32'd0);
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    tx_done_i = 1'b0;
    tx_delay = 3; early_done = 0; start_at = 0; reset_at = 0;
    nbytes = 0; n_done = 0; viol = 0; outstanding = 0; wait_cnt = 0;
    last_byte = 8'h00; total_bytes = 0;
    for (int k = 0; k < 32; k++) bank[k] = 32'hA0B0C000 + 32'(k);
    cycle();
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_cntl", 32'(cntl_read_debug_reg_o), 32'd0);
    check_eq("rst_txstart", 32'(tx_start_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_addr", 32'(addr_debug_unit_o), 32'd0);
    check_eq("rst_txdata", 32'(tx_data_o), 32'd0);
    repeat (2) cycle();

    run_dump("basic", 3, 0, 0, 0);
    if (cap.size() >= 24) begin
      check_eq("r5_b0", 32'(cap[20]), 32'h05);
      check_eq("r5_b1", 32'(cap[21]), 32'hC0);
      check_eq("r5_b2", 32'(cap[22]), 32'hB0);
      check_eq("r5_b3", 32'(cap[23]), 32'hA0);
    end else begin
      check_eq("r5_captured", 32'(cap.size()), 32'd24);
    end

    run_dump("slow", 20, 0, 0, 0);
    run_dump("ignore", 3, 1, 40, 0);

    run_dump("reset", 3, 0, 0, 50);
    run_dump("restart", 3, 0, 0, 0);
    if (cap.size() >= 2) begin
      check_eq("restart_b0", 32'(cap[0]), 32'h00);
      check_eq("restart_b1", 32'(cap[1]), 32'hC0);
    end else begin
      check_eq("restart_captured", 32'(cap.size()), 32'd2);
    end

    for (int k = 0; k < 32; k++) bank[k] = 32'h0;
    bank[1] = 32'h000000FF;
    run_dump("chk", 3, 0, 0, 0);
`ifdef DUMP_CHECKSUM_EN
    check_eq("chk_count", 32'(cap.size()), 32'd129);
    if (cap.size() > 0) check_eq("chk_last", 32'(cap[cap.size()-1]), 32'hFF);
`else
    check_eq("chk_count", 32'(cap.size()), 32'd128);
    if (cap.size() > 0) check_eq("chk_last", 32'(cap[cap.size()-1]), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
